// File: rtl/d7s_pkg.sv
// Shared definitions for the 7-segment capture path: select codes, segment patterns and
// the frame state type, plus the segment-to-BCD decode.
package d7s_pkg;

   localparam logic [2:0] SEL_U     = 3'b110;
   localparam logic [2:0] SEL_T     = 3'b101;
   localparam logic [2:0] SEL_H     = 3'b011;
   localparam logic [2:0] SEL_BLANK = 3'b111;

   // Active-low bus values, bit6..0 = A..G; same table the encoder drives.
   localparam logic [6:0] SEG_0 = ~7'b1111110;
   localparam logic [6:0] SEG_1 = ~7'b0110000;
   localparam logic [6:0] SEG_2 = ~7'b1101101;
   localparam logic [6:0] SEG_3 = ~7'b1111001;
   localparam logic [6:0] SEG_4 = ~7'b0110011;
   localparam logic [6:0] SEG_5 = ~7'b1011011;
   localparam logic [6:0] SEG_6 = ~7'b1011111;
   localparam logic [6:0] SEG_7 = ~7'b1110000;
   localparam logic [6:0] SEG_8 = ~7'b1111111;
   localparam logic [6:0] SEG_9 = ~7'b1111011;

   typedef enum logic [1:0] {WAIT_U, GOT_U, GOT_T} frame_state_e;

   // Returns {bad, digit}; bad is set for any pattern outside the ten digits.
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         SEG_0:   r = {1'b0, 4'd0};
         SEG_1:   r = {1'b0, 4'd1};
         SEG_2:   r = {1'b0, 4'd2};
         SEG_3:   r = {1'b0, 4'd3};
         SEG_4:   r = {1'b0, 4'd4};
         SEG_5:   r = {1'b0, 4'd5};
         SEG_6:   r = {1'b0, 4'd6};
         SEG_7:   r = {1'b0, 4'd7};
         SEG_8:   r = {1'b0, 4'd8};
         SEG_9:   r = {1'b0, 4'd9};
         default: r = {1'b1, 4'd0};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bcd2bin_seq.sv
// Iterative 3-digit BCD to binary converter (reverse double-dabble), one shift per cycle.
module bcd2bin_seq #(
   parameter int unsigned BIN_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [11:0]      bcd,
   output logic             busy,
   output logic             done,
   output logic [BIN_W-1:0] bin
);
   localparam int unsigned REG_W = 12 + BIN_W;
   localparam int unsigned IT_W  = $clog2(BIN_W);
   localparam logic [IT_W-1:0] LAST = IT_W'(BIN_W - 1);

   logic [REG_W-1:0] sr_q;
   logic [IT_W-1:0]  it_q;
   logic             busy_q, done_q;

   // A nibble that received a shifted-in tens bit reads >= 8; subtracting 3 rescales it.
   function automatic logic [REG_W-1:0] step(input logic [REG_W-1:0] r);
      logic [REG_W-1:0] s;
      s = r >> 1;
      for (int i = 0; i < 3; i++) begin
         if (s[BIN_W + 4*i + 3]) s[BIN_W + 4*i +: 4] = s[BIN_W + 4*i +: 4] - 4'd3;
      end
      return s;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q   <= '0;
         it_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start && !busy_q) begin
            sr_q   <= {bcd, {BIN_W{1'b0}}};
            it_q   <= '0;
            busy_q <= 1'b1;
         end else if (busy_q) begin
            sr_q <= step(sr_q);
            it_q <= it_q + IT_W'(1);
            if (it_q == LAST) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bin  = sr_q[BIN_W-1:0];

endmodule

// File: rtl/d7s_capture.sv
// Watches a multiplexed 7-segment display, reassembles units/tens/hundreds frames and
// reports the displayed number in binary.
module d7s_capture
   import d7s_pkg::*;
#(
   parameter int unsigned SETTLE = 2,
   parameter int unsigned CONV_W = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] transistor,
   input  logic [6:0] d7sp,
   output logic [7:0] value,
   output logic       value_valid,
   output logic       overflow,
   output logic       frame_err,
   output logic       busy
);
   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   logic [2:0]        sel_q;
   logic [3:0]        cnt_q, cnt_d;
   logic              sel_chg, sample_stb;
   logic              seg_bad;
   logic [3:0]        seg_digit;
   frame_state_e      state_q, state_d;
   logic [3:0]        d1_q, d1_d, d2_q, d2_d;
   logic              bad_q, bad_d, err_q, err_d;
   logic              conv_start, conv_busy, conv_done, conv_over;
   logic [CONV_W-1:0] conv_bin;
   logic [7:0]        conv_sat, value_q;

   assign {seg_bad, seg_digit} = seg_decode(d7sp);

   // Counter saturates at SETTLE so the strobe fires once per dwell.
   always_comb begin
      sel_chg = (transistor != sel_q);
      if (sel_chg)               cnt_d = 4'd1;
      else if (cnt_q < SETTLE_C) cnt_d = cnt_q + 4'd1;
      else                       cnt_d = cnt_q;
      sample_stb = (cnt_d == SETTLE_C) && (sel_chg || (cnt_q != SETTLE_C));
   end

   always_comb begin
      state_d    = state_q;
      d1_d       = d1_q;
      d2_d       = d2_q;
      bad_d      = bad_q;
      err_d      = 1'b0;
      conv_start = 1'b0;
      if (sample_stb) begin
         case (transistor)
            SEL_BLANK: ;
            SEL_U: begin
               d1_d    = seg_digit;
               bad_d   = seg_bad;
               state_d = GOT_U;
            end
            SEL_T: begin
               case (state_q)
                  GOT_U: begin
                     d2_d    = seg_digit;
                     bad_d   = bad_q | seg_bad;
                     state_d = GOT_T;
                  end
                  GOT_T: begin
                     err_d   = 1'b1;
                     state_d = WAIT_U;
                  end
                  default: ;
               endcase
            end
            SEL_H: begin
               case (state_q)
                  GOT_U: begin
                     err_d   = 1'b1;
                     state_d = WAIT_U;
                  end
                  GOT_T: begin
                     state_d = WAIT_U;
                     if (bad_q || seg_bad || conv_busy) err_d = 1'b1;
                     else                               conv_start = 1'b1;
                  end
                  default: ;
               endcase
            end
            default: begin
               err_d   = 1'b1;
               state_d = WAIT_U;
            end
         endcase
      end
   end

   bcd2bin_seq #(
      .BIN_W (CONV_W)
   ) u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bcd   ({seg_digit, d2_q, d1_q}),
      .busy  (conv_busy),
      .done  (conv_done),
      .bin   (conv_bin)
   );

   assign conv_over = (conv_bin > CONV_W'(255));
   assign conv_sat  = conv_over ? 8'hFF : conv_bin[7:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q   <= SEL_BLANK;
         cnt_q   <= '0;
         state_q <= WAIT_U;
         d1_q    <= '0;
         d2_q    <= '0;
         bad_q   <= 1'b0;
         err_q   <= 1'b0;
         value_q <= '0;
      end else begin
         sel_q   <= transistor;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
         if (conv_done) value_q <= conv_sat;
      end
   end

   // Result is presented in the done cycle itself, then held.
   always_comb begin
      value       = conv_done ? conv_sat : value_q;
      value_valid = conv_done;
      overflow    = conv_done & conv_over;
   end

   assign frame_err = err_q;
   assign busy      = conv_busy;

endmodule

// File: tb/tb_d7s_capture.sv
// Self-checking bench for d7s_capture: a driver model feeds frames, a scoreboard checks
// every value_valid pulse for value, overflow and arrival cycle.
module tb_d7s_capture;

   localparam logic [2:0] T_U = 3'b110;
   localparam logic [2:0] T_T = 3'b101;
   localparam logic [2:0] T_H = 3'b011;
   localparam logic [2:0] T_B = 3'b111;
   localparam logic [6:0] SEG_HI [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                          7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                          7'b1111111, 7'b1111011};
   localparam logic [6:0] SEG_JUNK = 7'b1111110;

   typedef struct {
      logic [7:0] val;
      logic       ov;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] transistor;
   logic [6:0] d7sp;
   logic [7:0] value;
   logic       value_valid, overflow, frame_err, busy;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   err_seen = 0;
   int   last_err_cyc = -1;
   int   h_cyc = 0;
   exp_t sb[$];
   exp_t mon_e;

   d7s_capture #(
      .SETTLE (2),
      .CONV_W (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .transistor  (transistor),
      .d7sp        (d7sp),
      .value       (value),
      .value_valid (value_valid),
      .overflow    (overflow),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_err === 1'b1) begin
         err_seen++;
         last_err_cyc = cyc;
      end
      if (value_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_valid cyc=%0d value=%0d required=no pulse", cyc, value);
         end else begin
            mon_e = sb.pop_front();
            if (value !== mon_e.val) begin
               failures++;
               $display("FAIL value got=%0d required=%0d", value, mon_e.val);
            end
            checks++;
            if (overflow !== mon_e.ov) begin
               failures++;
               $display("FAIL overflow got=%0b required=%0b (value %0d)", overflow, mon_e.ov,
                        mon_e.val);
            end
            checks++;
            if (cyc != mon_e.cyc) begin
               failures++;
               $display("FAIL latency got_cyc=%0d required_cyc=%0d", cyc, mon_e.cyc);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dwell(input logic [2:0] sel, input logic [6:0] seg, input int n);
      h_cyc      = cyc;
      transistor = sel;
      d7sp       = seg;
      repeat (n) tick();
   endtask

   // With SETTLE=2 the hundreds strobe is the 2nd dwell cycle; result 11 cycles later.
   task automatic push_exp(input int n, input int hc);
      exp_t e;
      e.ov  = (n > 255);
      e.val = e.ov ? 8'd255 : 8'(n);
      e.cyc = hc + 12;
      sb.push_back(e);
   endtask

   task automatic send_frame(input int n, input bit expect_out);
      dwell(T_U, ~SEG_HI[n % 10], 4);
      dwell(T_T, ~SEG_HI[(n / 10) % 10], 4);
      dwell(T_H, ~SEG_HI[n / 100], 4);
      if (expect_out) push_exp(n, h_cyc);
   endtask

   task automatic wait_drain();
      int k = 0;
      transistor = T_B;
      d7sp       = 7'h7F;
      while (sb.size() != 0 && k < 40) begin
         tick();
         k++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", sb.size());
         sb.delete();
      end
      repeat (2) tick();
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      transistor = T_B;
      d7sp       = 7'h7F;
      repeat (3) tick();
      checks += 5;
      if (value !== 8'd0) begin
         failures++; $display("FAIL reset_value got=%0d required=0", value);
      end
      if (value_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid got=%0b required=0", value_valid);
      end
      if (overflow !== 1'b0) begin
         failures++; $display("FAIL reset_overflow got=%0b required=0", overflow);
      end
      if (frame_err !== 1'b0) begin
         failures++; $display("FAIL reset_frame_err got=%0b required=0", frame_err);
      end
      if (busy !== 1'b0) begin
         failures++; $display("FAIL reset_busy got=%0b required=0", busy);
      end
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_basic();
      int e0 = err_seen;
      send_frame(123, 1'b1);
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL basic_busy got=%0b required=1", busy);
      end
      wait_drain();
      checks++;
      if (err_seen != e0) begin
         failures++; $display("FAIL basic_frame_err got=%0d required=0", err_seen - e0);
      end
   endtask

   task automatic test_sweep();
      int e0 = err_seen;
      for (int n = 0; n < 256; n++) send_frame(n, 1'b1);
      wait_drain();
      checks++;
      if (err_seen != e0) begin
         failures++; $display("FAIL sweep_frame_err got=%0d required=0", err_seen - e0);
      end
   endtask

   task automatic test_overflow();
      send_frame(952, 1'b1);
      wait_drain();
   endtask

   task automatic test_bad_tens();
      int e0 = err_seen;
      int hc;
      dwell(T_U, ~SEG_HI[1], 4);
      dwell(T_T, SEG_JUNK, 4);
      dwell(T_H, ~SEG_HI[3], 4);
      hc = h_cyc;
      dwell(T_B, 7'h7F, 6);
      checks++;
      if (err_seen - e0 != 1) begin
         failures++; $display("FAIL bad_tens_err_count got=%0d required=1", err_seen - e0);
      end
      checks++;
      if (last_err_cyc != hc + 2) begin
         failures++; $display("FAIL bad_tens_err_cyc got=%0d required=%0d", last_err_cyc, hc + 2);
      end
      send_frame(42, 1'b1);
      wait_drain();
      checks++;
      if (err_seen - e0 != 1) begin
         failures++; $display("FAIL bad_tens_recover got=%0d required=1", err_seen - e0);
      end
   endtask

   task automatic test_order_glitch();
      int e0 = err_seen;
      dwell(T_U, ~SEG_HI[1], 4);
      dwell(T_H, ~SEG_HI[2], 4);
      dwell(T_B, 7'h7F, 3);
      checks++;
      if (err_seen - e0 != 1) begin
         failures++; $display("FAIL order_err got=%0d required=1", err_seen - e0);
      end
      dwell(3'b000, ~SEG_HI[4], 4);
      dwell(T_B, 7'h7F, 3);
      checks++;
      if (err_seen - e0 != 2) begin
         failures++; $display("FAIL illegal_sel_err got=%0d required=2", err_seen - e0);
      end
      dwell(T_U, ~SEG_HI[5], 4);
      dwell(T_T, SEG_JUNK, 1);
      dwell(T_U, ~SEG_HI[5], 3);
      dwell(T_T, ~SEG_HI[6], 4);
      dwell(T_H, ~SEG_HI[1], 4);
      push_exp(165, h_cyc);
      wait_drain();
      checks++;
      if (err_seen - e0 != 2) begin
         failures++; $display("FAIL glitch_err got=%0d required=2", err_seen - e0);
      end
   endtask

   task automatic test_reset_mid();
      send_frame(77, 1'b0);
      dwell(T_B, 7'h7F, 2);
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL midrst_busy_before got=%0b required=1", busy);
      end
      rst = 1'b1;
      #1;
      checks += 4;
      if (value !== 8'd0) begin
         failures++; $display("FAIL midrst_value got=%0d required=0", value);
      end
      if (value_valid !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL midrst_valid_ovf got=%0b%0b required=00", value_valid, overflow);
      end
      if (frame_err !== 1'b0) begin
         failures++; $display("FAIL midrst_frame_err got=%0b required=0", frame_err);
      end
      if (busy !== 1'b0) begin
         failures++; $display("FAIL midrst_busy got=%0b required=0", busy);
      end
      repeat (2) tick();
      rst = 1'b0;
      repeat (2) tick();
      send_frame(200, 1'b1);
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sweep();
      test_overflow();
      test_bad_tens();
      test_order_glitch();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
